// File: rtl/axi_stream_strip_header.sv
// Strips a per-packet header of H bytes (0..W) from the front of an MSB-first byte stream,
// emitting the header on its own channel and the realigned payload with one cycle of latency.
module axi_stream_strip_header #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   valid_in,
  output logic                                   ready_in,
  input  logic [DATA_WD-1:0]                     data_in,
  input  logic [DATA_BYTE_WD-1:0]                keep_in,
  input  logic                                   last_in,
  input  logic                                   valid_len,
  output logic                                   ready_len,
  input  logic [$clog2(DATA_BYTE_WD+1)-1:0]      len_in,
  output logic                                   valid_hdr,
  input  logic                                   ready_hdr,
  output logic [DATA_WD-1:0]                     header_out,
  output logic [DATA_BYTE_WD-1:0]                keep_hdr,
  output logic                                   valid_out,
  input  logic                                   ready_out,
  output logic [DATA_WD-1:0]                     data_out,
  output logic [DATA_BYTE_WD-1:0]                keep_out,
  output logic                                   last_out
);

  localparam int unsigned LenWidth = $clog2(DATA_BYTE_WD + 1);
  // One spare bit so that R + n (up to 2W) cannot wrap.
  localparam int unsigned CntWidth = LenWidth + 1;
  localparam logic [CntWidth-1:0] BeatBytes = CntWidth'(DATA_BYTE_WD);

  typedef enum logic [1:0] {StWaitLen, StWaitFirst, StStream, StFlush} state_e;

  state_e              state_q;
  logic [CntWidth-1:0] h_q;
  logic [CntWidth-1:0] r_q;
  logic [DATA_WD-1:0]  res_q;  // residue bytes held top-aligned, zeros below

  logic [CntWidth-1:0] n_bytes;
  logic [CntWidth-1:0] r_first;
  logic [CntWidth-1:0] rn_sum;
  logic [DATA_WD-1:0]  in_top_n;
  logic [DATA_WD-1:0]  stream_word;
  logic [DATA_WD-1:0]  last_word;
  logic                out_free;
  logic                in_fire;

  function automatic logic [DATA_BYTE_WD-1:0] top_keep(input logic [CntWidth-1:0] k);
    return ~({DATA_BYTE_WD{1'b1}} >> k);
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] low_keep(input logic [CntWidth-1:0] k);
    return ~({DATA_BYTE_WD{1'b1}} << k);
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int b = 0; b < DATA_BYTE_WD; b++) begin
      m[b*8 +: 8] = {8{k[b]}};
    end
    return m;
  endfunction

  always_comb begin
    n_bytes = '0;
    for (int b = 0; b < DATA_BYTE_WD; b++) begin
      n_bytes = n_bytes + CntWidth'(keep_in[b]);
    end
  end

  assign r_first     = BeatBytes - h_q;
  assign rn_sum      = r_q + n_bytes;
  assign in_top_n    = data_in & byte_mask(keep_in);
  assign stream_word = res_q | (data_in >> {r_q, 3'b000});
  assign last_word   = res_q | (in_top_n >> {r_q, 3'b000});

  assign out_free  = !valid_out || ready_out;
  assign ready_len = rst_n && (state_q == StWaitLen);
  assign ready_in  = ((state_q == StWaitFirst) || (state_q == StStream)) && out_free &&
                     !(valid_hdr && !ready_hdr);
  assign in_fire   = valid_in && ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StWaitLen;
      h_q        <= '0;
      r_q        <= '0;
      res_q      <= '0;
      valid_hdr  <= 1'b0;
      header_out <= '0;
      keep_hdr   <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      keep_out   <= '0;
      last_out   <= 1'b0;
    end else begin
      if (valid_hdr && ready_hdr) valid_hdr <= 1'b0;
      if (valid_out && ready_out) valid_out <= 1'b0;

      unique case (state_q)
        StWaitLen: begin
          if (valid_len) begin
            h_q     <= {1'b0, len_in};
            state_q <= StWaitFirst;
          end
        end

        StWaitFirst: begin
          if (in_fire) begin
            header_out <= data_in >> {r_first, 3'b000};
            keep_hdr   <= low_keep(h_q);
            valid_hdr  <= 1'b1;
            res_q      <= data_in << {h_q, 3'b000};
            r_q        <= r_first;
            if (last_in) begin
              valid_out <= 1'b1;
              last_out  <= 1'b1;
              // A packet no longer than its header still closes with an empty beat.
              if (n_bytes > h_q) begin
                data_out <= in_top_n << {h_q, 3'b000};
                keep_out <= top_keep(n_bytes - h_q);
              end else begin
                data_out <= '0;
                keep_out <= '0;
              end
              state_q <= StWaitLen;
            end else begin
              state_q <= StStream;
            end
          end
        end

        StStream: begin
          if (in_fire) begin
            valid_out <= 1'b1;
            if (!last_in) begin
              data_out <= stream_word;
              keep_out <= '1;
              last_out <= 1'b0;
              res_q    <= data_in << {h_q, 3'b000};
            end else if (rn_sum <= BeatBytes) begin
              data_out <= last_word;
              keep_out <= top_keep(rn_sum);
              last_out <= 1'b1;
              state_q  <= StWaitLen;
            end else begin
              data_out <= stream_word;
              keep_out <= '1;
              last_out <= 1'b0;
              res_q    <= in_top_n << {h_q, 3'b000};
              r_q      <= n_bytes - h_q;
              state_q  <= StFlush;
            end
          end
        end

        StFlush: begin
          if (out_free) begin
            valid_out <= 1'b1;
            data_out  <= res_q;
            keep_out  <= top_keep(r_q);
            last_out  <= 1'b1;
            state_q   <= StWaitLen;
          end
        end

        default: state_q <= StWaitLen;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Scoreboard bench for axi_stream_strip_header at W=4: directed packets, mid-packet reset and
// randomly stalled back-to-back traffic checked against a byte-level repacking model.
`timescale 1ns/1ps
module tb_axi_stream_strip_header;

  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} beat_t;
  typedef struct packed {logic [31:0] d; logic [3:0] k;} hdr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        valid_len = 1'b0;
  logic        ready_len;
  logic [2:0]  len_in = '0;
  logic        valid_hdr;
  logic        ready_hdr;
  logic [31:0] header_out;
  logic [3:0]  keep_hdr;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;

  beat_t       exp_out_q[$];
  hdr_t        exp_hdr_q[$];
  logic [31:0] stim_q[$];
  int          checks = 0;
  int          errors = 0;
  int          out_bytes = 0;
  int          exp_bytes = 0;
  bit          stall_en = 1'b0;

  always #5 clk = ~clk;

  axi_stream_strip_header #(.DATA_WD(32), .DATA_BYTE_WD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .keep_in   (keep_in),
    .last_in   (last_in),
    .valid_len (valid_len),
    .ready_len (ready_len),
    .len_in    (len_in),
    .valid_hdr (valid_hdr),
    .ready_hdr (ready_hdr),
    .header_out(header_out),
    .keep_hdr  (keep_hdr),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out),
    .keep_out  (keep_out),
    .last_out  (last_out)
  );

  // Sink readiness, randomised only while stall_en is set.
  initial begin
    ready_out = 1'b1;
    ready_hdr = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_out = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      ready_hdr = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pops on handshakes, stability under back-pressure.
  initial begin : monitor
    beat_t e, prev_out;
    hdr_t  eh, prev_hdr;
    bit    prev_out_stall, prev_hdr_stall;
    prev_out_stall = 1'b0;
    prev_hdr_stall = 1'b0;
    prev_out = '0;
    prev_hdr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_out_stall = 1'b0;
        prev_hdr_stall = 1'b0;
      end else begin
        if (prev_out_stall) begin
          checks++;
          if (!valid_out || {data_out, keep_out, last_out} !== prev_out) begin
            errors++;
            $display("FAIL out_stable: got v=%b %h/%b/%b required v=1 %h/%b/%b", valid_out,
                     data_out, keep_out, last_out, prev_out.d, prev_out.k, prev_out.l);
          end
        end
        if (prev_hdr_stall) begin
          checks++;
          if (!valid_hdr || {header_out, keep_hdr} !== prev_hdr) begin
            errors++;
            $display("FAIL hdr_stable: got v=%b %h/%b required v=1 %h/%b", valid_hdr,
                     header_out, keep_hdr, prev_hdr.d, prev_hdr.k);
          end
        end
        if (valid_out && ready_out) begin
          checks++;
          out_bytes += $countones(keep_out);
          if (exp_out_q.size() == 0) begin
            errors++;
            $display("FAIL out_extra: got %h/%b/%b required no beat", data_out, keep_out,
                     last_out);
          end else begin
            e = exp_out_q.pop_front();
            if ({data_out, keep_out, last_out} !== e) begin
              errors++;
              $display("FAIL out_beat: got %h/%b/%b required %h/%b/%b", data_out, keep_out,
                       last_out, e.d, e.k, e.l);
            end
          end
        end
        if (valid_hdr && ready_hdr) begin
          checks++;
          if (exp_hdr_q.size() == 0) begin
            errors++;
            $display("FAIL hdr_extra: got %h/%b required no header", header_out, keep_hdr);
          end else begin
            eh = exp_hdr_q.pop_front();
            if ({header_out, keep_hdr} !== eh) begin
              errors++;
              $display("FAIL hdr: got %h/%b required %h/%b", header_out, keep_hdr, eh.d, eh.k);
            end
          end
        end
        prev_out_stall = valid_out && !ready_out;
        prev_out = {data_out, keep_out, last_out};
        prev_hdr_stall = valid_hdr && !ready_hdr;
        prev_hdr = {header_out, keep_hdr};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All driver tasks start and end 1 ns after a rising edge.
  task automatic drive_len(input int h);
    int t;
    valid_len = 1'b1;
    len_in = 3'(h);
    t = 0;
    @(negedge clk);
    while (!ready_len && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!ready_len) begin
      checks++;
      errors++;
      $display("FAIL len_timeout: got ready_len=0 required 1 within 1000 cycles");
    end
    @(posedge clk);
    #1;
    valid_len = 1'b0;
  endtask

  task automatic drive_beat(input logic [31:0] w, input logic [3:0] k, input logic l,
                            input int gap);
    int t;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    valid_len = 1'b1;  // must be ignored mid-packet
    valid_in = 1'b1;
    data_in = w;
    keep_in = k;
    last_in = l;
    t = 0;
    @(negedge clk);
    checks++;
    if (ready_len !== 1'b0) begin
      errors++;
      $display("FAIL len_mid: got ready_len=%b required 0", ready_len);
    end
    while (!ready_in && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!ready_in) begin
      checks++;
      errors++;
      $display("FAIL in_timeout: got ready_in=0 required 1 within 1000 cycles");
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    valid_len = 1'b0;
    last_in = 1'b0;
  endtask

  // Sends stim_q as one packet; with use_model the expected output is the byte-level repack.
  task automatic send_packet(input int h, input logic [3:0] lkeep, input int maxgap,
                             input bit use_model);
    logic [7:0]  bq[$];
    logic [31:0] w, hd, d;
    logic [3:0]  k;
    int          n, nb;
    n = $countones(lkeep);
    nb = stim_q.size();
    for (int i = 0; i < nb; i++) begin
      w = stim_q[i];
      for (int j = 0; j < 4; j++) begin
        if (i != nb - 1 || j < n) bq.push_back(w[31-8*j -: 8]);
      end
    end
    exp_bytes += (bq.size() > h) ? bq.size() - h : 0;
    if (use_model) begin
      w = stim_q[0];
      hd = '0;
      for (int j = 0; j < h; j++) hd = {hd[23:0], w[31-8*j -: 8]};
      exp_hdr_q.push_back({hd, 4'((1 << h) - 1)});
      if (bq.size() <= h) begin
        exp_out_q.push_back({32'h0, 4'b0000, 1'b1});
      end else begin
        for (int p = h; p < bq.size(); p += 4) begin
          d = '0;
          k = '0;
          for (int j = 0; j < 4; j++) begin
            if (p + j < bq.size()) begin
              d[31-8*j -: 8] = bq[p+j];
              k[3-j] = 1'b1;
            end
          end
          exp_out_q.push_back({d, k, (p + 4 >= bq.size())});
        end
      end
    end
    drive_len(h);
    for (int i = 0; i < nb; i++) begin
      drive_beat(stim_q[i], (i == nb - 1) ? lkeep : 4'hF, (i == nb - 1),
                 $urandom_range(0, maxgap));
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_out_q.size() != 0 || exp_hdr_q.size() != 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    valid_len = 1'b1;
    valid_in = 1'b1;
    keep_in = 4'hF;
    data_in = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ready_in, ready_len, valid_hdr, valid_out, last_out} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy_in/rdy_len/vh/vo/last=%b required 00000",
               {ready_in, ready_len, valid_hdr, valid_out, last_out});
    end
    checks++;
    if ({header_out, keep_hdr, data_out, keep_out} !== 72'h0) begin
      errors++;
      $display("FAIL reset_data: got hdr=%h/%b out=%h/%b required all zero", header_out,
               keep_hdr, data_out, keep_out);
    end
    valid_len = 1'b0;
    valid_in = 1'b0;
    data_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ready_len !== 1'b1 || ready_in !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready_len=%b ready_in=%b required 1 0", ready_len,
               ready_in);
    end
  endtask

  task automatic test_h2();
    exp_hdr_q.push_back({32'h0000_AABB, 4'b0011});
    exp_out_q.push_back({32'hCCDD_1122, 4'hF, 1'b0});
    exp_out_q.push_back({32'h3344_5566, 4'hF, 1'b1});
    stim_q.delete();
    stim_q.push_back(32'hAABB_CCDD);
    stim_q.push_back(32'h1122_3344);
    stim_q.push_back(32'h5566_BEEF);
    send_packet(2, 4'hC, 0, 1'b0);
    wait_drain();
    checks++;
    if (exp_out_q.size() != 0 || exp_hdr_q.size() != 0) begin
      errors++;
      $display("FAIL h2_drain: got %0d beats %0d hdrs pending required 0 0", exp_out_q.size(),
               exp_hdr_q.size());
    end
  endtask

  task automatic test_h1_flush();
    exp_hdr_q.push_back({32'h0000_00AA, 4'b0001});
    exp_out_q.push_back({32'hBBCC_DD11, 4'hF, 1'b0});
    exp_out_q.push_back({32'h2233_0000, 4'hC, 1'b1});
    stim_q.delete();
    stim_q.push_back(32'hAABB_CCDD);
    stim_q.push_back(32'h1122_33EE);
    send_packet(1, 4'hE, 0, 1'b0);
    wait_drain();
    checks++;
    if (exp_out_q.size() != 0 || exp_hdr_q.size() != 0) begin
      errors++;
      $display("FAIL h1_drain: got %0d beats %0d hdrs pending required 0 0", exp_out_q.size(),
               exp_hdr_q.size());
    end
  endtask

  task automatic test_h0_h4();
    exp_hdr_q.push_back({32'h0, 4'b0000});
    exp_out_q.push_back({32'h0102_0304, 4'hF, 1'b0});
    exp_out_q.push_back({32'h0506_0708, 4'hF, 1'b0});
    exp_out_q.push_back({32'h090A_0B00, 4'hE, 1'b1});
    stim_q.delete();
    stim_q.push_back(32'h0102_0304);
    stim_q.push_back(32'h0506_0708);
    stim_q.push_back(32'h090A_0B00);
    send_packet(0, 4'hE, 0, 1'b0);
    exp_hdr_q.push_back({32'hA1A2_A3A4, 4'b1111});
    exp_out_q.push_back({32'hB1B2_B3B4, 4'hF, 1'b0});
    exp_out_q.push_back({32'hC1C2_C3C4, 4'hF, 1'b1});
    stim_q.delete();
    stim_q.push_back(32'hA1A2_A3A4);
    stim_q.push_back(32'hB1B2_B3B4);
    stim_q.push_back(32'hC1C2_C3C4);
    send_packet(4, 4'hF, 0, 1'b0);
    wait_drain();
    checks++;
    if (exp_out_q.size() != 0 || exp_hdr_q.size() != 0) begin
      errors++;
      $display("FAIL h0h4_drain: got %0d beats %0d hdrs pending required 0 0",
               exp_out_q.size(), exp_hdr_q.size());
    end
  endtask

  task automatic test_single_beat();
    exp_hdr_q.push_back({32'h00AA_BBCC, 4'b0111});
    exp_out_q.push_back({32'h0, 4'b0000, 1'b1});
    stim_q.delete();
    stim_q.push_back(32'hAABB_CC77);
    send_packet(3, 4'hE, 0, 1'b0);
    exp_hdr_q.push_back({32'h0000_0012, 4'b0001});
    exp_out_q.push_back({32'h3456_0000, 4'hC, 1'b1});
    stim_q.delete();
    stim_q.push_back(32'h1234_5600);
    send_packet(1, 4'hE, 0, 1'b0);
    wait_drain();
    checks++;
    if (exp_out_q.size() != 0 || exp_hdr_q.size() != 0) begin
      errors++;
      $display("FAIL single_drain: got %0d beats %0d hdrs pending required 0 0",
               exp_out_q.size(), exp_hdr_q.size());
    end
  endtask

  task automatic test_mid_reset();
    drive_len(2);
    drive_beat(32'hDEAD_BEEF, 4'hF, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid_hdr, valid_out, ready_in, ready_len} !== 4'b0 || header_out !== 32'h0) begin
      errors++;
      $display("FAIL midrst: got vh/vo/rdy_in/rdy_len=%b hdr=%h required 0000 0",
               {valid_hdr, valid_out, ready_in, ready_len}, header_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    stim_q.delete();
    stim_q.push_back(32'h0A0B_0C0D);
    stim_q.push_back(32'h0E0F_1011);
    send_packet(3, 4'hF, 0, 1'b1);
    wait_drain();
    checks++;
    if (exp_out_q.size() != 0 || exp_hdr_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_drain: got %0d beats %0d hdrs pending required 0 0",
               exp_out_q.size(), exp_hdr_q.size());
    end
  endtask

  task automatic test_random_stall();
    int          h, nb, n;
    logic [31:0] w;
    logic [3:0]  lk;
    out_bytes = 0;
    exp_bytes = 0;
    stall_en = 1'b1;
    for (int p = 0; p < 40; p++) begin
      h = $urandom_range(0, 4);
      nb = $urandom_range(1, 4);
      n = $urandom_range(1, 4);
      lk = 4'(4'hF << (4 - n));
      stim_q.delete();
      for (int i = 0; i < nb; i++) begin
        w = $urandom();
        if (i == nb - 1) begin
          for (int j = 0; j < 4; j++) if (!lk[j]) w[j*8 +: 8] = 8'h00;
        end
        stim_q.push_back(w);
      end
      send_packet(h, lk, 2, 1'b1);
    end
    stall_en = 1'b0;
    wait_drain();
    checks++;
    if (exp_out_q.size() != 0 || exp_hdr_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got %0d beats %0d hdrs pending required 0 0",
               exp_out_q.size(), exp_hdr_q.size());
    end
    checks++;
    if (out_bytes != exp_bytes) begin
      errors++;
      $display("FAIL rand_bytes: got %0d payload bytes required %0d", out_bytes, exp_bytes);
    end
  endtask

  initial begin
    test_reset();
    test_h2();
    test_h1_flush();
    test_h0_h4();
    test_single_beat();
    test_mid_reset();
    test_random_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_stream_strip_header.md
AXI_STREAM_STRIP_HEADER -- requirements
Module: axi_stream_strip_header

Interface
REQ-001 Parameter DATA_WD, default 32, stream data width in bits (multiple of 8).
REQ-002 Parameter DATA_BYTE_WD, default DATA_WD/8, bytes per beat (W below).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 valid_in / ready_in  input / output  1 / 1  handshake for the incoming stream that carries the header.
REQ-006 data_in  input  DATA_WD  input data; byte 0 sits at data_in[DATA_WD-1 -: 8] (MSB-first).
REQ-007 keep_in  input  DATA_BYTE_WD  byte enables, MSB-contiguous (e.g. 4'b1100); all ones on every non-last beat.
REQ-008 last_in  input  1  final beat of the packet.
REQ-009 valid_len / ready_len  input / output  1 / 1  handshake for the per-packet header length.
REQ-010 len_in  input  clog2(W+1)  header length H in bytes, 0..W; values above W are illegal.
REQ-011 valid_hdr / ready_hdr  output / input  1 / 1  handshake for the extracted header.
REQ-012 header_out / keep_hdr  output  DATA_WD / DATA_BYTE_WD  header bytes right-aligned in the low H bytes, with keep_hdr = (1<<H)-1.
REQ-013 valid_out / ready_out  output / input  1 / 1  handshake for the payload stream with the header removed.
REQ-014 data_out / keep_out / last_out  output  DATA_WD / DATA_BYTE_WD / 1  realigned payload; MSB-first, keep MSB-contiguous.

Function
REQ-015 The FSM shall have four states.
- WAIT_LEN: ready_len=1. On a len handshake, latch H and go to WAIT_FIRST.
- WAIT_FIRST: accepts the first data beat.
- STREAM: accepts the remaining beats.
- FLUSH: emits the residual beat.
REQ-016 ready_in shall be 1 only in WAIT_FIRST or STREAM, and only while (!valid_out || ready_out) && !(valid_hdr && !ready_hdr).
REQ-017 On the first-beat handshake, the block shall do all of the following:
- Set header_out = data_in >> ((W-H)*8), with the upper bytes zero.
- Set keep_hdr = (1<<H)-1 and assert valid_hdr.
- Store the low W-H bytes of data_in in the residue register, with residue count R = W-H.
REQ-018 valid_hdr and header_out shall hold until ready_hdr; exactly one header handshake occurs per packet, including H=0 (keep_hdr=0).
REQ-019 On each non-last STREAM beat, the next-cycle output shall be:
- data_out = {residue R bytes, top H bytes of data_in}, keep_out all ones, last_out=0.
- The residue shall then be reloaded with the low W-H bytes of data_in.
REQ-020 On the last beat with n = popcount(keep_in) valid bytes:
- If R+n <= W, emit one beat {residue, top n bytes}, zero-padded, with keep_out = top (R+n) ones and last_out=1, then go to WAIT_LEN.
- Otherwise emit a full beat with last_out=0, go to FLUSH, and next emit bytes n-H top-aligned with keep_out = top (n-H) ones and last_out=1, then go to WAIT_LEN.
REQ-021 A first beat that is also last shall be handled as follows:
- If n > H, emit one payload beat of n-H bytes, top-aligned, last_out=1.
- If n <= H, emit one beat with keep_out=0, data_out=0, last_out=1.
- In both cases the header is still emitted with keep_hdr=(1<<H)-1.
REQ-022 H=W shall give R=0: the first beat is header only with no payload output, and later beats pass through unchanged.
REQ-023 H=0 shall give full pass-through: data_out=data_in and keep_out=keep_in on every beat, with the same last_out.
REQ-024 Latency shall be one cycle: payload output registers update on the cycle after the input handshake that completes them.
REQ-025 The output registers (data_out, keep_out, last_out, valid_out) shall hold stable while valid_out && !ready_out.
REQ-026 valid_out shall clear after a ready_out handshake when no new beat is produced that cycle.
REQ-027 In FLUSH, ready_in shall be 0; the flush beat loads when the output register is free.
REQ-028 ready_len shall be 0 in every state except WAIT_LEN, so a new length is never taken mid-packet.
REQ-029 Arithmetic on R, n and H shall be done in clog2(W+1)+1 bits to avoid overflow in R+n.

Reset
REQ-030 While rst_n=0, the following shall all be zero:
- State WAIT_LEN, with ready_in=0 and ready_len=0.
- valid_hdr, header_out and keep_hdr.
- valid_out, data_out, keep_out and last_out.
- The residue register, R and H.
REQ-031 Reset asserted mid-packet shall discard all partial state; the first len handshake after release starts a fresh packet.

Verification (W=4)
REQ-032 H=2; input beats 0xAABBCCDD/F, 0x11223344/F, 0x5566xxxx/C last -> header 0x0000AABB keep 0011; payload 0xCCDD1122/F, then 0x33445566/F last.
REQ-033 H=1; input beats 0xAABBCCDD/F, 0x112233xx/E last -> header 0x000000AA keep 0001; payload 0xBBCCDD11/F, then FLUSH 0x22330000/C last.
REQ-034 H=0, then H=4, each with a 3-beat packet -> H=0 gives identical pass-through and keep_hdr=0; H=4 gives header = beat 0 and payload = beats 1..2 unchanged.
REQ-035 H=3; single beat 0xAABBCCxx/E last -> header 0x00AABBCC keep 0111; payload one beat keep 0000 last.
REQ-036 Random stall test: toggle ready_out and ready_hdr randomly, run back-to-back packets with random H -> no beat lost or duplicated, outputs stable under stall, payload byte count = input bytes - H per packet.
